// File: rtl/uart_packet_sender_pkg.sv
// Shared definitions for the UART packet sender.
// Contents: default header byte, packet FSM states, byte-push handshake
// sub-states, and a checksum helper.
package uart_packet_sender_pkg;

    localparam logic [7:0] HEADER_DEF = 8'hA5;

    // Packet framing states: one byte is emitted in every state except IDLE.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_ID,
        ST_LEN,
        ST_DATA,
        ST_CSUM
    } pkt_state_e;

    // Byte-push handshake sub-states.
    typedef enum logic {
        PS_WAIT_SPACE,
        PS_REQ
    } push_state_e;

    // Two's-complement checksum byte: makes the running sum wrap to zero.
    function automatic logic [7:0] csum_byte(input logic [7:0] acc);
        return 8'h00 - acc;
    endfunction

endpackage

// File: rtl/uart_byte_push.sv
// Pushes one byte at a time into the uart_comm send buffer.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   byte_req       a byte is waiting to be sent (level)
//   byte_in        byte to send, sampled when the request is issued
//   send_flag/send_data/send_ack/sendable  uart_comm send interface
//   byte_done      pulse: current byte acked (same cycle as the sampled ack)
//   byte_timeout   pulse: no ack within ACK_TIMEOUT cycles, request dropped
module uart_byte_push
    import uart_packet_sender_pkg::*;
#(
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       byte_req,
    input  logic [7:0] byte_in,
    input  logic       send_ack,
    input  logic       sendable,
    output logic       send_flag,
    output logic [7:0] send_data,
    output logic       byte_done,
    output logic       byte_timeout
);

    localparam int CW = $clog2(ACK_TIMEOUT) + 1;

    push_state_e   state_q;
    logic          flag_q;
    logic [7:0]    data_q;
    logic [CW-1:0] tmo_q;
    logic          tmo_hit;

    assign tmo_hit      = (tmo_q == CW'(ACK_TIMEOUT - 1));
    // An ack only counts while we are requesting, so a held-high ack is
    // consumed once and the state leaves REQ on that same edge.
    assign byte_done    = (state_q == PS_REQ) && send_ack;
    assign byte_timeout = (state_q == PS_REQ) && !send_ack && tmo_hit;

    assign send_flag = flag_q;
    assign send_data = data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PS_WAIT_SPACE;
            flag_q  <= 1'b0;
            data_q  <= 8'h00;
            tmo_q   <= '0;
        end else begin
            case (state_q)
                PS_WAIT_SPACE: begin
                    // Waiting for space never advances the timeout counter.
                    if (byte_req && sendable) begin
                        state_q <= PS_REQ;
                        flag_q  <= 1'b1;
                        data_q  <= byte_in;
                        tmo_q   <= '0;
                    end
                end
                PS_REQ: begin
                    if (byte_done || byte_timeout) begin
                        state_q <= PS_WAIT_SPACE;
                        flag_q  <= 1'b0;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= PS_WAIT_SPACE;
                    flag_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_packet_sender.sv
// Frames a packet request as HEADER, id, len, payload (LSB byte first),
// checksum and feeds it byte by byte into uart_comm.
// Ports:
//   CLK, RST                       clock, synchronous active-high reset
//   pkt_valid/pkt_ready            request handshake (ready only in IDLE)
//   pkt_id/pkt_nbytes/pkt_data     packet request fields, captured on accept
//   send_flag/send_data/send_ack/sendable  uart_comm send interface
//   busy                           packet in progress
//   done                           pulse when the checksum byte is acked
//   timeout_err                    pulse when a byte ack times out
module uart_packet_sender
    import uart_packet_sender_pkg::*;
#(
    parameter int          DATA_W      = 64,
    parameter logic [7:0]  HEADER      = HEADER_DEF,
    parameter int          ACK_TIMEOUT = 1024,
    parameter int          NB_W        = $clog2(DATA_W/8) + 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              pkt_valid,
    output logic              pkt_ready,
    input  logic [7:0]        pkt_id,
    input  logic [NB_W-1:0]   pkt_nbytes,
    input  logic [DATA_W-1:0] pkt_data,
    output logic              send_flag,
    output logic [7:0]        send_data,
    input  logic              send_ack,
    input  logic              sendable,
    output logic              busy,
    output logic              done,
    output logic              timeout_err
);

    localparam int NBYTES = DATA_W / 8;

    pkt_state_e        state_q;
    logic [7:0]        id_q;
    logic [NB_W-1:0]   len_q;
    logic [NB_W-1:0]   idx_q;
    logic [DATA_W-1:0] data_q;
    logic [7:0]        csum_q;
    logic              done_q;
    logic              tmo_err_q;

    logic [NB_W-1:0]   len_d;
    logic [7:0]        byte_d;
    logic              byte_done;
    logic              byte_tmo;

    assign len_d = (pkt_nbytes > NB_W'(NBYTES)) ? NB_W'(NBYTES) : pkt_nbytes;

    // Byte for the current state; payload is shifted down so byte 0 leads.
    always_comb begin
        byte_d = HEADER;
        case (state_q)
            ST_ID:   byte_d = id_q;
            ST_LEN:  byte_d = 8'(len_q);
            ST_DATA: byte_d = data_q[7:0];
            ST_CSUM: byte_d = csum_byte(csum_q);
            default: byte_d = HEADER;
        endcase
    end

    uart_byte_push #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_push (
        .clk          (CLK),
        .rst          (RST),
        .byte_req     (state_q != ST_IDLE),
        .byte_in      (byte_d),
        .send_ack     (send_ack),
        .sendable     (sendable),
        .send_flag    (send_flag),
        .send_data    (send_data),
        .byte_done    (byte_done),
        .byte_timeout (byte_tmo)
    );

    assign pkt_ready   = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign timeout_err = tmo_err_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            id_q      <= 8'h00;
            len_q     <= '0;
            idx_q     <= '0;
            data_q    <= '0;
            csum_q    <= 8'h00;
            done_q    <= 1'b0;
            tmo_err_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            tmo_err_q <= 1'b0;
            if (state_q == ST_IDLE) begin
                if (pkt_valid) begin
                    id_q    <= pkt_id;
                    len_q   <= len_d;
                    data_q  <= pkt_data;
                    idx_q   <= '0;
                    csum_q  <= 8'h00;
                    state_q <= ST_HDR;
                end
            end else if (byte_tmo) begin
                state_q   <= ST_IDLE;
                tmo_err_q <= 1'b1;
            end else if (byte_done) begin
                case (state_q)
                    ST_HDR: state_q <= ST_ID;
                    ST_ID: begin
                        csum_q  <= csum_q + byte_d;
                        state_q <= ST_LEN;
                    end
                    ST_LEN: begin
                        csum_q  <= csum_q + byte_d;
                        state_q <= (len_q == '0) ? ST_CSUM : ST_DATA;
                    end
                    ST_DATA: begin
                        csum_q <= csum_q + byte_d;
                        data_q <= data_q >> 8;
                        if (idx_q == len_q - 1'b1) state_q <= ST_CSUM;
                        else                       idx_q   <= idx_q + 1'b1;
                    end
                    ST_CSUM: begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_packet_sender.sv
module tb_uart_packet_sender;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        pkt_valid = 1'b0;
    logic [7:0]  pkt_id = 8'h00;
    logic [3:0]  pkt_nbytes = 4'd0;
    logic [63:0] pkt_data = 64'h0;
    logic        send_ack = 1'b0;
    logic        sendable = 1'b1;
    logic        pkt_ready, send_flag, busy, done, timeout_err;
    logic [7:0]  send_data;

    always #5 CLK = ~CLK;

    uart_packet_sender #(
        .DATA_W      (64),
        .HEADER      (8'hA5),
        .ACK_TIMEOUT (16)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .pkt_valid   (pkt_valid),
        .pkt_ready   (pkt_ready),
        .pkt_id      (pkt_id),
        .pkt_nbytes  (pkt_nbytes),
        .pkt_data    (pkt_data),
        .send_flag   (send_flag),
        .send_data   (send_data),
        .send_ack    (send_ack),
        .sendable    (sendable),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err)
    );

    int checks = 0;
    int passes = 0;

    logic [7:0] got[$];     // bytes accepted by the fake uart_comm
    logic [7:0] exp_q[$];   // reference packet from the model

    int done_cnt = 0, tmo_cnt = 0;
    int bp_at = -1, nack_at = -1, bp_left = 0, bp_viol = 0;
    int stab_viol = 0, hi_run = 0, last_run = 0;
    int ack_wait = 0, ack_delay = 0;
    logic [7:0] ack_byte = 8'h00, prev_data = 8'h00;
    logic       prev_flag = 1'b0;

    // Fake uart_comm: acks each request after a random delay, records the
    // accepted byte, optionally withholds space or an ack at a chosen byte.
    always @(negedge CLK) begin
        if (send_ack) begin
            send_ack = 1'b0;
            got.push_back(ack_byte);
            if (got.size() == bp_at) begin
                bp_left  = 50;
                sendable = 1'b0;
            end
        end else if (send_flag && got.size() != nack_at) begin
            if (ack_wait >= ack_delay) begin
                send_ack  = 1'b1;
                ack_byte  = send_data;
                ack_wait  = 0;
                ack_delay = $urandom_range(0, 3);
            end else begin
                ack_wait++;
            end
        end
        if (bp_left > 0) begin
            if (send_flag) bp_viol++;
            bp_left--;
            if (bp_left == 0) sendable = 1'b1;
        end
        if (send_flag) hi_run++;
        else begin
            if (hi_run != 0) last_run = hi_run;
            hi_run = 0;
        end
        if (send_flag && prev_flag && send_data !== prev_data) stab_viol++;
        prev_flag = send_flag;
        prev_data = send_data;
        if (done) done_cnt++;
        if (timeout_err) tmo_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference framing from the packet rules.
    task automatic build_exp(input logic [7:0] id, input logic [3:0] n, input logic [63:0] d);
        int len;
        int sum;
        len = (n > 8) ? 8 : int'(n);
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(id);
        exp_q.push_back(8'(len));
        sum = int'(id) + len;
        for (int i = 0; i < len; i++) begin
            exp_q.push_back(d[8*i +: 8]);
            sum += int'(d[8*i +: 8]);
        end
        exp_q.push_back(8'((256 - (sum % 256)) % 256));
    endtask

    task automatic start_pkt(input logic [7:0] id, input logic [3:0] n, input logic [63:0] d);
        @(negedge CLK);
        chk("ready_before_accept", 32'(pkt_ready), 1);
        pkt_valid  = 1'b1;
        pkt_id     = id;
        pkt_nbytes = n;
        pkt_data   = d;
        @(negedge CLK);
        pkt_valid  = 1'b0;
        pkt_id     = 8'($urandom);
        pkt_nbytes = 4'($urandom);
        pkt_data   = {$urandom, $urandom};
        chk("busy_after_accept", 32'(busy), 1);
    endtask

    task automatic wait_end(input string tag, input int d0, input int t0);
        int n;
        n = 0;
        while (done_cnt == d0 && tmo_cnt == t0 && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        chk({tag, "_end_in_time"}, 32'(n < 3000), 1);
    endtask

    task automatic chk_bytes(input string tag, input int base);
        chk({tag, "_nbytes"}, 32'(got.size() - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            logic [7:0] ob;
            ob = (base + i < got.size()) ? got[base + i] : 8'hxx;
            chk($sformatf("%s_byte%0d", tag, i), 32'(ob), 32'(exp_q[i]));
        end
    endtask

    task automatic run_pkt(input string tag, input logic [7:0] id, input logic [3:0] n, input logic [63:0] d);
        int base, d0, t0;
        base = got.size();
        d0   = done_cnt;
        t0   = tmo_cnt;
        build_exp(id, n, d);
        start_pkt(id, n, d);
        wait_end(tag, d0, t0);
        chk_bytes(tag, base);
        chk({tag, "_done_once"}, 32'(done_cnt - d0), 1);
        chk({tag, "_no_tmo"}, 32'(tmo_cnt - t0), 0);
        @(negedge CLK);
        chk({tag, "_idle"}, 32'({busy, pkt_ready, done}), 32'(3'b010));
    endtask

    initial begin
        int base, d0, t0, n, s;

        // Reset state
        repeat (3) @(negedge CLK);
        chk("rst_ready", 32'(pkt_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_flag", 32'(send_flag), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_tmo", 32'(timeout_err), 0);
        RST = 1'b0;

        // Basic packet
        run_pkt("basic", 8'h12, 4'd2, 64'hBEEF);
        chk("basic_csum_lit", 32'(got[got.size() - 1]), 32'h3F);

        // Zero payload
        run_pkt("zero", 8'h01, 4'd0, {$urandom, $urandom});
        chk("zero_csum_lit", 32'(got[got.size() - 1]), 32'hFF);

        // Length clamp
        base = got.size();
        run_pkt("clamp", 8'($urandom), 4'd15, {$urandom, $urandom});
        chk("clamp_len", 32'(got[base + 2]), 8);
        s = 0;
        for (int i = 1; i < got.size() - base; i++) s += int'(got[base + i]);
        chk("clamp_sum_zero", 32'(s % 256), 0);

        // Backpressure before the 3rd byte
        bp_at = got.size() + 2;
        run_pkt("bp", 8'($urandom), 4'd3, {$urandom, $urandom});
        chk("bp_flag_low", 32'(bp_viol), 0);
        bp_at = -1;

        // Ack timeout on the id byte
        base = got.size(); d0 = done_cnt; t0 = tmo_cnt;
        nack_at = base + 1;
        start_pkt(8'h5A, 4'd2, 64'h1234);
        wait_end("tmo", d0, t0);
        chk("tmo_pulse", 32'(tmo_cnt - t0), 1);
        chk("tmo_no_done", 32'(done_cnt - d0), 0);
        chk("tmo_flag_cycles", 32'(last_run), 16);
        chk("tmo_bytes_sent", 32'(got.size() - base), 1);
        chk("tmo_ready", 32'(pkt_ready), 1);
        chk("tmo_busy", 32'(busy), 0);
        chk("tmo_flag", 32'(send_flag), 0);
        nack_at = -1;
        run_pkt("after_tmo", 8'($urandom), 4'($urandom_range(0, 8)), {$urandom, $urandom});

        // Reset while the 2nd payload byte is requested
        base = got.size(); d0 = done_cnt; t0 = tmo_cnt;
        nack_at = base + 4;
        start_pkt(8'h77, 4'd4, {$urandom, $urandom});
        n = 0;
        while (!(send_flag && got.size() == base + 4) && n < 200) begin
            @(negedge CLK);
            n++;
        end
        chk("rst_mid_reached", 32'(n < 200), 1);
        RST = 1'b1;
        @(negedge CLK);
        chk("rst_mid_flag", 32'(send_flag), 0);
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_ready", 32'(pkt_ready), 1);
        RST = 1'b0;
        nack_at = -1;
        chk("rst_mid_no_done", 32'(done_cnt - d0), 0);
        chk("rst_mid_no_tmo", 32'(tmo_cnt - t0), 0);
        run_pkt("after_rst", 8'($urandom), 4'($urandom_range(0, 8)), {$urandom, $urandom});

        // Random packets
        for (int k = 0; k < 6; k++)
            run_pkt($sformatf("rnd%0d", k), 8'($urandom), 4'($urandom_range(0, 15)), {$urandom, $urandom});

        chk("data_stable_while_flag", 32'(stab_viol), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
